// File: rtl/dt_pass_seq.sv
// Two-pass (forward/backward) raster sequencer for a distance-transform datapath.
// Initialises the result memory, then sweeps interior pixels forward and backward.
module dt_pass_seq #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int AW     = 14,
  parameter int NLOAD  = 4,
  parameter int BORDER = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          dp_ready,
  output logic [AW-1:0] pix_addr,
  output logic [1:0]    phase,
  output logic          sti_rd,
  output logic          res_rd,
  output logic [2:0]    load_cnt,
  output logic          op_en,
  output logic          res_wr,
  output logic          busy,
  output logic          done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_FIRST = CW'(BORDER);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1 - BORDER);
  localparam logic [RW-1:0] ROW_FIRST = RW'(BORDER);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1 - BORDER);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] FWD_START = AW'(BORDER * IMG_W + BORDER);
  localparam logic [AW-1:0] ROW_STEP  = AW'(2 * BORDER + 1);
  localparam logic [2:0]    LAST_LOAD = 3'(NLOAD - 1);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_FWD  = 2'd2;
  localparam logic [1:0] PH_BWD  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_OP, S_WB, S_DONE} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          sti_q, rd_q, op_q, wr_q;

  // Strobes are gated by dp_ready so a stalled cycle never issues a memory access.
  assign sti_rd = sti_q & dp_ready;
  assign res_rd = rd_q  & dp_ready;
  assign op_en  = op_q  & dp_ready;
  assign res_wr = wr_q  & dp_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      pix_addr <= '0;
      phase    <= PH_IDLE;
      load_cnt <= '0;
      sti_q    <= 1'b0;
      rd_q     <= 1'b0;
      op_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_INIT;
            phase    <= PH_INIT;
            pix_addr <= '0;
            row      <= '0;
            col      <= '0;
            load_cnt <= '0;
            sti_q    <= 1'b1;
            wr_q     <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_INIT: if (dp_ready) begin
          if (pix_addr == LAST_ADDR) begin
            state    <= S_LOAD;
            phase    <= PH_FWD;
            row      <= ROW_FIRST;
            col      <= COL_FIRST;
            pix_addr <= FWD_START;
            load_cnt <= '0;
            sti_q    <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b1;
          end else begin
            pix_addr <= pix_addr + AW'(1);
          end
        end

        S_LOAD: if (dp_ready) begin
          if (load_cnt == LAST_LOAD) begin
            state    <= S_OP;
            load_cnt <= '0;
            rd_q     <= 1'b0;
            op_q     <= 1'b1;
          end else begin
            load_cnt <= load_cnt + 3'd1;
          end
        end

        S_OP: if (dp_ready) begin
          state <= S_WB;
          op_q  <= 1'b0;
          wr_q  <= 1'b1;
        end

        S_WB: if (dp_ready) begin
          wr_q <= 1'b0;
          if (phase == PH_FWD) begin
            state <= S_LOAD;
            rd_q  <= 1'b1;
            if (row == ROW_LAST && col == COL_LAST) begin
              // Backward start pixel equals the last forward pixel, so row/col/addr stay put.
              phase <= PH_BWD;
            end else if (col == COL_LAST) begin
              col      <= COL_FIRST;
              row      <= row + RW'(1);
              pix_addr <= pix_addr + ROW_STEP;
            end else begin
              col      <= col + CW'(1);
              pix_addr <= pix_addr + AW'(1);
            end
          end else begin
            if (row == ROW_FIRST && col == COL_FIRST) begin
              state <= S_DONE;
              phase <= PH_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
              rd_q  <= 1'b1;
              if (col == COL_FIRST) begin
                col      <= COL_LAST;
                row      <= row - RW'(1);
                pix_addr <= pix_addr - ROW_STEP;
              end else begin
                col      <= col - CW'(1);
                pix_addr <= pix_addr - AW'(1);
              end
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_pass_seq.sv
// Self-checking bench for dt_pass_seq on a 4x4 image: per-cycle scoreboard plus spot-check table.
module tb_dt_pass_seq;

  logic       clk = 1'b0;
  logic       reset, start, dp_ready;
  logic [3:0] pix_addr;
  logic [1:0] phase;
  logic       sti_rd, res_rd, op_en, res_wr, busy, done;
  logic [2:0] load_cnt;

  dt_pass_seq #(.IMG_W(4), .IMG_H(4), .AW(4), .NLOAD(4), .BORDER(1)) dut (
    .clk(clk), .reset(reset), .start(start), .dp_ready(dp_ready),
    .pix_addr(pix_addr), .phase(phase), .sti_rd(sti_rd), .res_rd(res_rd),
    .load_cnt(load_cnt), .op_en(op_en), .res_wr(res_wr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [1:0] ph;
    logic       sti, rrd;
    logic [2:0] lc;
    logic       op, wr, bsy, dn;
    bit         chk_lc, chk_ap;
  } rec_t;

  typedef struct {
    int         run;
    int         cyc;
    bit         chk_addr;
    logic [3:0] addr;
    logic       bsy;
    logic       dn;
  } spot_t;

  rec_t  exp_q[$];
  spot_t spots[10];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] a, input logic [1:0] p, input logic s, input logic r,
                              input logic [2:0] l, input logic o, input logic w, input logic b,
                              input logic d, input bit clc, input bit cap);
    rec_t t;
    t.addr = a; t.ph = p; t.sti = s; t.rrd = r; t.lc = l; t.op = o; t.wr = w;
    t.bsy = b; t.dn = d; t.chk_lc = clc; t.chk_ap = cap;
    return t;
  endfunction

  task automatic push_pixel(input logic [3:0] a, input logic [1:0] p);
    for (int l = 0; l < 4; l++) exp_q.push_back(mk(a, p, 0, 1, 3'(l), 0, 0, 1, 0, 1, 1));
    exp_q.push_back(mk(a, p, 0, 0, 3'd0, 1, 0, 1, 0, 0, 1));
    exp_q.push_back(mk(a, p, 0, 0, 3'd0, 0, 1, 1, 0, 0, 1));
  endtask

  // Expected trace from cycle 1 onward; stall inserts held copies at cycle 19 (FWD pixel 5, load_cnt 2).
  task automatic build(input bit stall);
    int   fwd_list[4];
    rec_t r;
    fwd_list = '{5, 6, 9, 10};
    exp_q.delete();
    for (int a = 0; a < 16; a++) exp_q.push_back(mk(4'(a), 2'd1, 1, 0, 3'd0, 0, 1, 1, 0, 0, 1));
    for (int p = 0; p < 4; p++) push_pixel(4'(fwd_list[p]), 2'd2);
    for (int p = 3; p >= 0; p--) push_pixel(4'(fwd_list[p]), 2'd3);
    exp_q.push_back(mk(4'd0, 2'd0, 0, 0, 3'd0, 0, 0, 1, 1, 0, 0));
    if (stall) begin
      r = exp_q[18];
      r.rrd = 1'b0;
      for (int k = 0; k < 3; k++) exp_q.insert(18, r);
    end
  endtask

  task automatic run(input int run_id, input bit stall, input bit pulses);
    int   c;
    int   dones;
    rec_t e, g;
    build(stall);
    dones = 0;
    @(posedge clk); #1;
    start = 1'b1; dp_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
      start    = pulses && (c == 10 || c == 30);
      dp_ready = !(stall && c >= 19 && c <= 21);
      @(negedge clk);
      e = exp_q.pop_front();
      g = mk(pix_addr, phase, sti_rd, res_rd, load_cnt, op_en, res_wr, busy, done, e.chk_lc, e.chk_ap);
      if (!e.chk_lc) g.lc = e.lc;
      if (!e.chk_ap) begin g.addr = e.addr; g.ph = e.ph; end
      check($sformatf("run%0d cyc%0d trace", run_id, c),
            {g.addr, g.ph, g.sti, g.rrd, g.lc, g.op, g.wr, g.bsy, g.dn},
            {e.addr, e.ph, e.sti, e.rrd, e.lc, e.op, e.wr, e.bsy, e.dn});
      if (done) dones++;
      for (int s = 0; s < 10; s++) begin
        if (spots[s].run == run_id && spots[s].cyc == c) begin
          check($sformatf("run%0d spot cyc%0d busy/done", run_id, c), {busy, done}, {spots[s].bsy, spots[s].dn});
          if (spots[s].chk_addr) check($sformatf("run%0d spot cyc%0d addr", run_id, c), pix_addr, spots[s].addr);
        end
      end
    end
    check($sformatf("run%0d trace complete", run_id), exp_q.size(), 0);
    start = 1'b0; dp_ready = 1'b1;
    @(negedge clk);
    check($sformatf("run%0d idle after done", run_id), {busy, done, sti_rd, res_rd, op_en, res_wr}, 6'b0);
    check($sformatf("run%0d done pulse count", run_id), dones, 1);
  endtask

  initial begin
    int found;
    spots[0] = '{0,  1, 1, 4'd0,  1, 0};
    spots[1] = '{0, 16, 1, 4'd15, 1, 0};
    spots[2] = '{0, 17, 1, 4'd5,  1, 0};
    spots[3] = '{0, 40, 1, 4'd10, 1, 0};
    spots[4] = '{0, 41, 1, 4'd10, 1, 0};
    spots[5] = '{0, 64, 1, 4'd5,  1, 0};
    spots[6] = '{0, 65, 0, 4'd0,  1, 1};
    spots[7] = '{1, 20, 1, 4'd5,  1, 0};
    spots[8] = '{1, 65, 0, 4'd0,  1, 0};
    spots[9] = '{1, 68, 0, 4'd0,  1, 1};

    reset = 1'b0; start = 1'b0; dp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {pix_addr, phase, sti_rd, res_rd, load_cnt, op_en, res_wr, busy, done}, 16'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle after reset", {busy, done, phase}, 4'b0);

    run(0, 1'b0, 1'b1);
    run(1, 1'b1, 1'b0);

    // Mid-pass reset at the backward visit of pixel 9.
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk);
      if (phase == 2'd3 && pix_addr == 4'd9) found = 1;
    end
    check("reached BWD pixel 9", found, 1);
    reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("mid-pass reset outputs", {pix_addr, phase, sti_rd, res_rd, load_cnt, op_en, res_wr, busy, done}, 16'b0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("restart INIT addr/phase", {pix_addr, phase}, {4'd0, 2'd1});
    check("restart INIT strobes", {sti_rd, res_rd, op_en, res_wr, busy}, 5'b10011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
